// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM.
// One access is granted per cycle. Reads return with a fixed master-side
// latency of 2: one cycle for the RAM and one for the data register.
module onchip_mem_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);

  typedef enum logic { PRIO_M0 = 1'b0, PRIO_M1 = 1'b1 } prio_t;
  typedef enum logic { OWN_M0 = 1'b0, OWN_M1 = 1'b1 } owner_t;

  prio_t             prio_q, prio_d;
  logic              req0, req1;
  logic              grant0, grant1;
  logic              issue_rd;
  owner_t            issue_own;
  logic              rd_v1, rd_v2;
  owner_t            rd_o1, rd_o2;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grant decision and next priority pointer; prio only moves on a contested cycle
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    prio_d = prio_q;
    if (req0 && req1) begin
      if (ROUND_ROBIN != 0) begin
        if (prio_q == PRIO_M0) begin
          grant0 = 1'b1;
          prio_d = PRIO_M1;
        end else begin
          grant1 = 1'b1;
          prio_d = PRIO_M0;
        end
      end else begin
        grant0 = 1'b1;
      end
    end else begin
      grant0 = req0;
      grant1 = req1;
    end
  end

  // Priority pointer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio_q <= PRIO_M0;
    else       prio_q <= prio_d;
  end

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  // RAM-side mux from the granted master; read+write together counts as a write
  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    issue_rd       = 1'b0;
    issue_own      = OWN_M0;
    if (grant0) begin
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      issue_rd       = m0_read & ~m0_write;
      issue_own      = OWN_M0;
    end else if (grant1) begin
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      issue_rd       = m1_read & ~m1_write;
      issue_own      = OWN_M1;
    end
  end

  // Two-stage read return pipeline; stage 1 captures RAM q into the owner's register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_v1    <= 1'b0;
      rd_o1    <= OWN_M0;
      rd_v2    <= 1'b0;
      rd_o2    <= OWN_M0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rd_v1 <= issue_rd;
      rd_o1 <= issue_own;
      rd_v2 <= rd_v1;
      rd_o2 <= rd_o1;
      if (rd_v1) begin
        if (rd_o1 == OWN_M0) rdata0_q <= mem_readdata;
        else                 rdata1_q <= mem_readdata;
      end
    end
  end

  assign m0_readdata      = rdata0_q;
  assign m1_readdata      = rdata1_q;
  assign m0_readdatavalid = rd_v2 & (rd_o2 == OWN_M0);
  assign m1_readdatavalid = rd_v2 & (rd_o2 == OWN_M1);

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: a round-robin and a fixed-priority instance
// share the master stimulus, each with its own RAM, and are compared every
// cycle against a transaction-level model (memory image + return queue).
module tb_onchip_mem_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic              ram_init;
  logic [1:0]        rd_i, wr_i;
  logic [1:0][11:0]  addr_i;
  logic [1:0][3:0]   be_i;
  logic [1:0][31:0]  wd_i;

  // [dut][master]; dut 0 = round-robin, dut 1 = fixed priority
  logic        wait_o [2][2];
  logic        rdv_o  [2][2];
  logic [31:0] rdd_o  [2][2];

  // model state
  typedef struct { int due; int d; int m; logic [31:0] data; } pend_t;
  pend_t       pq[$];
  logic [31:0] ref_mem [2][4096];
  int          m_prio  [2];
  logic [31:0] last_rd [2][2];
  logic        exp_v   [2][2];
  int          cyc;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int a);
    logic [31:0] t;
    t = 32'(a + 1);
    return (a == 5) ? 32'hDEADBEEF : (32'h9E3779B9 * t);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        w0, w1, v0, v1;
    logic [31:0] d0, d1;
    logic [11:0] ma;
    logic [3:0]  mbe;
    logic        mcs, mwe;
    logic [31:0] mwd, mrd;
    logic [31:0] ram [4096];
    logic [11:0] aq;

    onchip_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .ROUND_ROBIN((g == 0) ? 1 : 0)) dut (
      .clk(clk), .reset(rst),
      .m0_address(addr_i[0]), .m0_byteenable(be_i[0]), .m0_read(rd_i[0]), .m0_write(wr_i[0]),
      .m0_writedata(wd_i[0]), .m0_waitrequest(w0), .m0_readdata(d0), .m0_readdatavalid(v0),
      .m1_address(addr_i[1]), .m1_byteenable(be_i[1]), .m1_read(rd_i[1]), .m1_write(wr_i[1]),
      .m1_writedata(wd_i[1]), .m1_waitrequest(w1), .m1_readdata(d1), .m1_readdatavalid(v1),
      .mem_address(ma), .mem_byteenable(mbe), .mem_chipselect(mcs), .mem_write(mwe),
      .mem_writedata(mwd), .mem_readdata(mrd)
    );

    // RAM: registered address, unregistered q
    always @(posedge clk) begin
      if (ram_init) begin
        for (int a = 0; a < 4096; a++) ram[a] <= init_word(a);
        aq <= '0;
      end else if (mcs) begin
        aq <= ma;
        if (mwe) ram[ma] <= merge(ram[ma], mwd, mbe);
      end
    end
    assign mrd = ram[aq];

    assign wait_o[g][0] = w0;
    assign wait_o[g][1] = w1;
    assign rdv_o[g][0]  = v0;
    assign rdv_o[g][1]  = v1;
    assign rdd_o[g][0]  = d0;
    assign rdd_o[g][1]  = d1;
  end

  // ---------------- reference model ----------------
  function automatic int grant_of(input int d);
    bit r0, r1;
    r0 = rd_i[0] | wr_i[0];
    r1 = rd_i[1] | wr_i[1];
    if (r0 && r1) return (d == 0) ? m_prio[d] : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic logic exp_wait(input int d, input int m);
    return (rd_i[m] | wr_i[m]) && (grant_of(d) != m);
  endfunction

  task automatic model_reset();
    pq.delete();
    for (int d = 0; d < 2; d++) begin
      m_prio[d] = 0;
      for (int m = 0; m < 2; m++) begin
        last_rd[d][m] = '0;
        exp_v[d][m]   = 1'b0;
      end
    end
  endtask

  // settle combinational outputs, then retire returns due this cycle
  task automatic settle();
    pend_t e;
    #1;
    for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) exp_v[d][m] = 1'b0;
    while (pq.size() > 0 && pq[0].due == cyc) begin
      e = pq.pop_front();
      exp_v[e.d][e.m]   = 1'b1;
      last_rd[e.d][e.m] = e.data;
    end
  endtask

  // apply this cycle's accepted access to the model, then move to next cycle
  task automatic commit();
    int    g;
    pend_t e;
    bit    contested;
    contested = (rd_i[0] | wr_i[0]) && (rd_i[1] | wr_i[1]);
    for (int d = 0; d < 2; d++) begin
      g = grant_of(d);
      if (g >= 0) begin
        if (wr_i[g]) begin
          ref_mem[d][addr_i[g]] = merge(ref_mem[d][addr_i[g]], wd_i[g], be_i[g]);
        end else begin
          e.due = cyc + 2; e.d = d; e.m = g; e.data = ref_mem[d][addr_i[g]];
          pq.push_back(e);
        end
      end
      if (contested && d == 0) m_prio[d] = 1 - m_prio[d];
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_m(input int m, input bit r, input bit w, input logic [11:0] a,
                       input logic [3:0] be, input logic [31:0] dat);
    rd_i[m] = r; wr_i[m] = w; addr_i[m] = a; be_i[m] = be; wd_i[m] = dat;
  endtask

  task automatic idle();
    set_m(0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, '0, '0, '0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; ram_init = 1'b1; idle();
    for (int d = 0; d < 2; d++) for (int a = 0; a < 4096; a++) ref_mem[d][a] = init_word(a);
    model_reset();
    @(negedge clk); @(negedge clk);
    ram_init = 1'b0;
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) begin
      checks++;
      if (rdv_o[d][m] !== 1'b0) begin errors++;
        $display("FAIL reset_rdv d%0d m%0d got %b want 0", d, m, rdv_o[d][m]); end
      checks++;
      if (rdd_o[d][m] !== 32'h0) begin errors++;
        $display("FAIL reset_rdd d%0d m%0d got %h want 0", d, m, rdd_o[d][m]); end
      checks++;
      if (wait_o[d][m] !== 1'b0) begin errors++;
        $display("FAIL reset_wait d%0d m%0d got %b want 0", d, m, wait_o[d][m]); end
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_basic_read();
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i == 0) set_m(0, 1, 0, 12'h005, 4'hF, '0);
      settle();
      for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) begin
        checks++; if (wait_o[d][m] !== exp_wait(d, m)) begin errors++;
          $display("FAIL basic_wait d%0d m%0d got %b want %b", d, m, wait_o[d][m], exp_wait(d, m)); end
        checks++; if (rdv_o[d][m] !== exp_v[d][m]) begin errors++;
          $display("FAIL basic_rdv d%0d m%0d got %b want %b", d, m, rdv_o[d][m], exp_v[d][m]); end
        checks++; if (rdd_o[d][m] !== last_rd[d][m]) begin errors++;
          $display("FAIL basic_rdd d%0d m%0d got %h want %h", d, m, rdd_o[d][m], last_rd[d][m]); end
      end
      if (i == 2) begin
        checks++; if (rdv_o[0][0] !== 1'b1 || rdd_o[0][0] !== 32'hDEADBEEF) begin errors++;
          $display("FAIL basic_deadbeef got v=%b d=%h want v=1 d=deadbeef", rdv_o[0][0], rdd_o[0][0]); end
      end
      commit();
    end
  endtask

  task automatic test_write_readback();
    for (int i = 0; i < 8; i++) begin
      idle();
      case (i)
        0: set_m(1, 0, 1, 12'h00A, 4'hF, 32'h12345678);
        1: set_m(1, 1, 0, 12'h00A, 4'hF, '0);
        4: set_m(1, 0, 1, 12'h00A, 4'h3, 32'hFFFFFFFF);
        5: set_m(1, 1, 0, 12'h00A, 4'hF, '0);
        default: ;
      endcase
      settle();
      for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) begin
        checks++; if (wait_o[d][m] !== exp_wait(d, m)) begin errors++;
          $display("FAIL wrrb_wait d%0d m%0d got %b want %b", d, m, wait_o[d][m], exp_wait(d, m)); end
        checks++; if (rdv_o[d][m] !== exp_v[d][m]) begin errors++;
          $display("FAIL wrrb_rdv d%0d m%0d got %b want %b", d, m, rdv_o[d][m], exp_v[d][m]); end
        checks++; if (rdd_o[d][m] !== last_rd[d][m]) begin errors++;
          $display("FAIL wrrb_rdd d%0d m%0d got %h want %h", d, m, rdd_o[d][m], last_rd[d][m]); end
      end
      if (i == 3) begin
        checks++; if (rdv_o[0][1] !== 1'b1 || rdd_o[0][1] !== 32'h12345678) begin errors++;
          $display("FAIL wrrb_full got v=%b d=%h want v=1 d=12345678", rdv_o[0][1], rdd_o[0][1]); end
      end
      if (i == 7) begin
        checks++; if (rdv_o[0][1] !== 1'b1 || rdd_o[0][1] !== 32'h1234FFFF) begin errors++;
          $display("FAIL wrrb_partial got v=%b d=%h want v=1 d=1234ffff", rdv_o[0][1], rdd_o[0][1]); end
      end
      commit();
    end
  endtask

  task automatic test_round_robin();
    int cnt [2][2];
    for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) cnt[d][m] = 0;
    for (int i = 0; i < 9; i++) begin
      idle();
      if (i < 6) begin
        set_m(0, 1, 0, 12'(12'h100 + i), 4'hF, '0);
        set_m(1, 1, 0, 12'(12'h200 + i), 4'hF, '0);
      end
      settle();
      for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) begin
        if (rdv_o[d][m] === 1'b1) cnt[d][m]++;
        checks++; if (wait_o[d][m] !== exp_wait(d, m)) begin errors++;
          $display("FAIL rr_wait d%0d m%0d got %b want %b", d, m, wait_o[d][m], exp_wait(d, m)); end
        checks++; if (rdv_o[d][m] !== exp_v[d][m]) begin errors++;
          $display("FAIL rr_rdv d%0d m%0d got %b want %b", d, m, rdv_o[d][m], exp_v[d][m]); end
        checks++; if (rdd_o[d][m] !== last_rd[d][m]) begin errors++;
          $display("FAIL rr_rdd d%0d m%0d got %h want %h", d, m, rdd_o[d][m], last_rd[d][m]); end
      end
      if (i < 6) begin
        checks++; if (wait_o[0][0] !== 1'(i % 2) || wait_o[0][1] !== 1'((i + 1) % 2)) begin errors++;
          $display("FAIL rr_alternate cycle %0d got w0=%b w1=%b want w0=%0d w1=%0d",
                   i, wait_o[0][0], wait_o[0][1], i % 2, (i + 1) % 2); end
      end
      commit();
    end
    checks++; if (cnt[0][0] != 3 || cnt[0][1] != 3) begin errors++;
      $display("FAIL rr_pulses got m0=%0d m1=%0d want 3 3", cnt[0][0], cnt[0][1]); end
    checks++; if (cnt[1][0] != 6 || cnt[1][1] != 0) begin errors++;
      $display("FAIL fp_pulses got m0=%0d m1=%0d want 6 0", cnt[1][0], cnt[1][1]); end
  endtask

  task automatic test_fixed_priority();
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i < 4) set_m(0, 1, 0, 12'(12'h300 + i), 4'hF, '0);
      if (i < 5) set_m(1, 1, 0, 12'h400, 4'hF, '0);
      settle();
      for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) begin
        checks++; if (wait_o[d][m] !== exp_wait(d, m)) begin errors++;
          $display("FAIL fp_wait d%0d m%0d got %b want %b", d, m, wait_o[d][m], exp_wait(d, m)); end
        checks++; if (rdv_o[d][m] !== exp_v[d][m]) begin errors++;
          $display("FAIL fp_rdv d%0d m%0d got %b want %b", d, m, rdv_o[d][m], exp_v[d][m]); end
        checks++; if (rdd_o[d][m] !== last_rd[d][m]) begin errors++;
          $display("FAIL fp_rdd d%0d m%0d got %h want %h", d, m, rdd_o[d][m], last_rd[d][m]); end
      end
      if (i < 5) begin
        checks++; if (wait_o[1][1] !== ((i < 4) ? 1'b1 : 1'b0)) begin errors++;
          $display("FAIL fp_m1_stall cycle %0d got %b want %b", i, wait_o[1][1], (i < 4)); end
      end
      commit();
    end
  endtask

  task automatic test_rw_violation();
    for (int i = 0; i < 7; i++) begin
      idle();
      if (i == 0) set_m(0, 1, 1, 12'h020, 4'hF, 32'hA5A5A5A5);
      if (i == 4) set_m(0, 1, 0, 12'h020, 4'hF, '0);
      settle();
      for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) begin
        checks++; if (wait_o[d][m] !== exp_wait(d, m)) begin errors++;
          $display("FAIL rw_wait d%0d m%0d got %b want %b", d, m, wait_o[d][m], exp_wait(d, m)); end
        checks++; if (rdv_o[d][m] !== exp_v[d][m]) begin errors++;
          $display("FAIL rw_rdv d%0d m%0d got %b want %b", d, m, rdv_o[d][m], exp_v[d][m]); end
        checks++; if (rdd_o[d][m] !== last_rd[d][m]) begin errors++;
          $display("FAIL rw_rdd d%0d m%0d got %h want %h", d, m, rdd_o[d][m], last_rd[d][m]); end
      end
      if (i == 2) begin
        checks++; if (rdv_o[0][0] !== 1'b0) begin errors++;
          $display("FAIL rw_no_response got %b want 0", rdv_o[0][0]); end
      end
      if (i == 6) begin
        checks++; if (rdv_o[0][0] !== 1'b1 || rdd_o[0][0] !== 32'hA5A5A5A5) begin errors++;
          $display("FAIL rw_readback got v=%b d=%h want v=1 d=a5a5a5a5", rdv_o[0][0], rdd_o[0][0]); end
      end
      commit();
    end
  endtask

  task automatic test_reset_midflight();
    idle();
    set_m(1, 1, 0, 12'h00A, 4'hF, '0);
    settle();
    commit();
    idle();
    rst = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) begin
      checks++; if (rdv_o[d][m] !== 1'b0 || rdd_o[d][m] !== 32'h0) begin errors++;
        $display("FAIL midrst_cleared d%0d m%0d got v=%b d=%h want 0", d, m, rdv_o[d][m], rdd_o[d][m]); end
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i == 4) begin
        set_m(0, 1, 0, 12'h005, 4'hF, '0);
        set_m(1, 1, 0, 12'h00A, 4'hF, '0);
      end
      settle();
      for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) begin
        checks++; if (wait_o[d][m] !== exp_wait(d, m)) begin errors++;
          $display("FAIL midrst_wait d%0d m%0d got %b want %b", d, m, wait_o[d][m], exp_wait(d, m)); end
        checks++; if (rdv_o[d][m] !== exp_v[d][m]) begin errors++;
          $display("FAIL midrst_rdv d%0d m%0d got %b want %b", d, m, rdv_o[d][m], exp_v[d][m]); end
        checks++; if (rdd_o[d][m] !== last_rd[d][m]) begin errors++;
          $display("FAIL midrst_rdd d%0d m%0d got %h want %h", d, m, rdd_o[d][m], last_rd[d][m]); end
      end
      if (i == 4) begin
        checks++; if (wait_o[0][0] !== 1'b0 || wait_o[0][1] !== 1'b1) begin errors++;
          $display("FAIL midrst_prio got w0=%b w1=%b want w0=0 w1=1", wait_o[0][0], wait_o[0][1]); end
      end
      commit();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 403; i++) begin
      idle();
      if (i < 400) begin
        for (int m = 0; m < 2; m++)
          set_m(m, ($urandom_range(9, 0) < 4), ($urandom_range(9, 0) < 3),
                12'(12'h040 + $urandom_range(15, 0)), 4'($urandom_range(15, 0)), $urandom);
      end
      settle();
      for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) begin
        checks++; if (wait_o[d][m] !== exp_wait(d, m)) begin errors++;
          $display("FAIL rand_wait cyc %0d d%0d m%0d got %b want %b", cyc, d, m, wait_o[d][m], exp_wait(d, m)); end
        checks++; if (rdv_o[d][m] !== exp_v[d][m]) begin errors++;
          $display("FAIL rand_rdv cyc %0d d%0d m%0d got %b want %b", cyc, d, m, rdv_o[d][m], exp_v[d][m]); end
        checks++; if (rdd_o[d][m] !== last_rd[d][m]) begin errors++;
          $display("FAIL rand_rdd cyc %0d d%0d m%0d got %h want %h", cyc, d, m, rdd_o[d][m], last_rd[d][m]); end
      end
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_write_readback();
    test_round_robin();
    test_fixed_priority();
    test_rw_violation();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
